// File: rtl/bp_update_sched_pkg.sv
// Shared types and constants for the bimodal branch predictor
// update path.
package bp_update_sched_pkg;

  localparam int BP_XLEN = 64;
  localparam int BP_IDX_LSB = 2;
  localparam int BP_IDX_MSB = 7;
  localparam int BP_IDX_W = BP_IDX_MSB - BP_IDX_LSB + 1;
  localparam int BP_TBL_SIZE = 64;
  localparam logic [1:0] BP_INIT_STATE = 2'b10;

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } state_t;

  typedef struct packed {
    logic [BP_IDX_W-1:0] idx;
    logic [BP_XLEN-1:0]  target;
    logic                taken;
  } bp_update_t;

endpackage

// File: rtl/bp_update_fifo.sv
// Small synchronous FIFO with synchronous clear; push is ignored
// when full and pop when empty, so callers may gate loosely.
module bp_update_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok && !rst && !clr) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (pop_ok) begin
        rptr <= rptr + AW'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bp_update_sched.sv
// Predictor write scheduler: sweeps the tables after reset/flush,
// then drains queued branch updates one write per cycle.
module bp_update_sched
  import bp_update_sched_pkg::*;
#(
  parameter int         XLEN       = BP_XLEN,
  parameter int         IDX_W      = BP_IDX_W,
  parameter int         DEPTH      = 4,
  parameter logic [1:0] INIT_STATE = BP_INIT_STATE
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             ex_valid_i,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  logic [XLEN-1:0]  ex_target_i,
  input  logic             ex_taken_i,
  output logic             cmd_valid_o,
  output logic             cmd_init_o,
  output logic [IDX_W-1:0] cmd_idx_o,
  output logic             cmd_taken_o,
  output logic [XLEN-1:0]  cmd_target_o,
  output logic             pred_en_o,
  output logic             busy_o,
  output logic [15:0]      drop_cnt_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = IDX_W + XLEN + 1;
  localparam logic [IDX_W-1:0] LAST = '1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bp_update_sched: DEPTH must be a power of two >= 2");
  end
  if ($bits(INIT_STATE) != 2) begin : g_bad_init
    $error("bp_update_sched: INIT_STATE must be 2 bits");
  end

  state_t           state;
  logic [IDX_W-1:0] sweep_idx;
  logic [15:0]      drop_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [FW-1:0]    fifo_din;
  logic [FW-1:0]    fifo_dout;
  logic             push;
  logic             pop;
  logic             unused;

  // Flush-cycle enqueues are discarded, never counted as drops.
  assign push = ex_valid_i & ~fifo_full & ~flush_i;
  assign pop  = (state == RUN) & ~fifo_empty;

  assign fifo_din = {ex_pc_i[IDX_W+1:2], ex_target_i, ex_taken_i};

  bp_update_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .clr   (flush_i),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= SWEEP;
      sweep_idx <= '0;
    end else if (flush_i) begin
      state     <= SWEEP;
      sweep_idx <= '0;
    end else begin
      unique case (state)
        SWEEP: begin
          sweep_idx <= sweep_idx + IDX_W'(1);
          if (sweep_idx == LAST) begin
            state     <= RUN;
            sweep_idx <= '0;
          end
        end
        RUN: begin
          sweep_idx <= '0;
        end
        default: begin
          state     <= SWEEP;
          sweep_idx <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt <= '0;
    end else if (!flush_i && ex_valid_i && fifo_full
                 && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign cmd_init_o   = (state == SWEEP);
  assign cmd_valid_o  = (state == SWEEP) | pop;
  assign cmd_idx_o    = (state == SWEEP) ? sweep_idx
                                         : fifo_dout[FW-1 -: IDX_W];
  assign cmd_target_o = fifo_dout[XLEN:1];
  assign cmd_taken_o  = fifo_dout[0];
  assign busy_o       = (state == SWEEP);
  assign pred_en_o    = (state == RUN);
  assign drop_cnt_o   = drop_cnt;

  assign unused = ^{ex_pc_i[XLEN-1:IDX_W+2], ex_pc_i[1:0], fifo_count};

endmodule

// File: tb/tb_bp_update_sched.sv
// Directed bench for bp_update_sched: sweep, update issue, overflow,
// flush and drop-counter saturation.
module tb_bp_update_sched;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        ex_valid;
  logic [63:0] ex_pc;
  logic [63:0] ex_target;
  logic        ex_taken;
  logic        cmd_valid;
  logic        cmd_init;
  logic [5:0]  cmd_idx;
  logic        cmd_taken;
  logic [63:0] cmd_target;
  logic        pred_en;
  logic        busy;
  logic [15:0] drop_cnt;

  int total = 0;
  int fails = 0;

  bp_update_sched dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .ex_valid_i   (ex_valid),
    .ex_pc_i      (ex_pc),
    .ex_target_i  (ex_target),
    .ex_taken_i   (ex_taken),
    .cmd_valid_o  (cmd_valid),
    .cmd_init_o   (cmd_init),
    .cmd_idx_o    (cmd_idx),
    .cmd_taken_o  (cmd_taken),
    .cmd_target_o (cmd_target),
    .pred_en_o    (pred_en),
    .busy_o       (busy),
    .drop_cnt_o   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs,
                     input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // {valid, init, busy, pred_en, idx} during a sweep write
  task automatic chk_sweep(input int j);
    logic [9:0] e;
    e = {4'b1110, 6'(j)};
    chk("sweep", {cmd_valid, cmd_init, busy, pred_en, cmd_idx}, e);
  endtask

  task automatic chk_idle();
    chk("idle", {cmd_valid, cmd_init, busy, pred_en}, 4'b0001);
  endtask

  task automatic chk_upd(input string tag, input logic [5:0] idx,
                         input logic tk, input logic [63:0] tgt);
    chk(tag, {cmd_valid, cmd_init, cmd_idx, cmd_taken, cmd_target},
        {1'b1, 1'b0, idx, tk, tgt});
  endtask

  initial begin
    logic [15:0] exp_drop;
    rst = 1'b1;
    flush = 1'b0;
    ex_valid = 1'b0;
    ex_pc = '0;
    ex_target = '0;
    ex_taken = 1'b0;
    step();
    step();

    // reset values
    chk("rst_ctl", {cmd_valid, cmd_init, cmd_idx, busy, pred_en},
        {1'b1, 1'b1, 6'd0, 1'b1, 1'b0});
    chk("rst_drop", drop_cnt, 16'd0);
    rst = 1'b0;

    // initial sweep
    for (int j = 0; j < 64; j++) begin
      chk_sweep(j);
      step();
    end
    chk_idle();
    step();
    chk_idle();

    // single update in RUN
    ex_valid = 1'b1;
    ex_pc = 64'h1004;
    ex_target = 64'h2000;
    ex_taken = 1'b1;
    step();
    ex_valid = 1'b0;
    chk_upd("upd1", 6'd1, 1'b1, 64'h2000);
    step();
    chk_idle();

    // overflow during sweep: 6 pushes, 4 kept
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_drop = 16'd0;
    for (int j = 0; j < 64; j++) begin
      chk_sweep(j);
      ex_valid = (j < 6);
      ex_pc = 64'(4 * (10 + j));
      ex_target = 64'(16'h100 * (j + 1));
      ex_taken = j[0];
      step();
    end
    ex_valid = 1'b0;
    exp_drop = 16'd2;
    for (int k = 0; k < 4; k++) begin
      chk_upd("ovf_q", 6'(10 + k), k[0], 64'(16'h100 * (k + 1)));
      step();
    end
    chk_idle();
    chk("ovf_drop", drop_cnt, exp_drop);

    // flush at sweep index 30 restarts the sweep
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int j = 0; j <= 30; j++) begin
      chk_sweep(j);
      ex_valid = (j == 5);
      ex_pc = 64'h40;
      flush = (j == 30);
      step();
    end
    ex_valid = 1'b0;
    flush = 1'b0;
    for (int j = 0; j < 64; j++) begin
      chk_sweep(j);
      step();
    end
    chk_idle();

    // flush discards 3 queued plus same-cycle enqueue
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int j = 0; j <= 10; j++) begin
      ex_valid = (j < 3) || (j == 10);
      ex_pc = 64'(4 * (20 + j));
      flush = (j == 10);
      step();
    end
    ex_valid = 1'b0;
    flush = 1'b0;
    for (int j = 0; j < 64; j++) begin
      chk_sweep(j);
      step();
    end
    for (int k = 0; k < 3; k++) begin
      chk_idle();
      step();
    end
    chk("fl3_drop", drop_cnt, exp_drop);

    // flush with a full FIFO plus enqueue: no drop counted
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int j = 0; j <= 4; j++) begin
      ex_valid = 1'b1;
      ex_pc = 64'(4 * (40 + j));
      flush = (j == 4);
      step();
    end
    ex_valid = 1'b0;
    flush = 1'b0;
    chk("flf_drop", drop_cnt, exp_drop);
    for (int j = 0; j < 64; j++) begin
      chk_sweep(j);
      step();
    end
    chk_idle();

    // sustained traffic in RUN: one cmd per cycle, count 1
    for (int k = 0; k < 8; k++) begin
      ex_valid = 1'b1;
      ex_pc = 64'(4 * (50 + k));
      ex_target = 64'(32'hA000 + k);
      ex_taken = ~k[0];
      step();
      chk_upd("sus", 6'(50 + k), ~k[0], 64'(32'hA000 + k));
      chk("sus_cnt", dut.u_fifo.count, 3'd1);
    end
    ex_valid = 1'b0;
    step();
    chk_idle();
    chk("sus_drop", drop_cnt, exp_drop);

    // forced-full drops until saturation
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int p = 0; p < 1200; p++) begin
      for (int c = 0; c < 64; c++) begin
        ex_valid = 1'b1;
        flush = (c == 63);
        step();
      end
      if (p == 0) begin
        exp_drop = exp_drop + 16'd59;
        chk("sat_p0", drop_cnt, exp_drop);
      end
    end
    ex_valid = 1'b0;
    flush = 1'b0;
    chk("sat_max", drop_cnt, 16'hFFFF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int c = 0; c < 20; c++) begin
      ex_valid = 1'b1;
      step();
    end
    ex_valid = 1'b0;
    chk("sat_hold", drop_cnt, 16'hFFFF);

    // reset clears the drop counter
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_drop", drop_cnt, 16'd0);
    chk_sweep(0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
